// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Start/stop sequencer for the JESD204 TPL DAC datapath: arm, wait for a stable link,
// optional external trigger, one-cycle datapath sync, then run with underflow monitoring.
module ad_ip_jesd204_tpl_dac_start_ctrl #(
  parameter int NUM_CHANNELS       = 2,
  parameter int LINK_STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_arm,
  input  logic                    cfg_stop,
  input  logic                    cfg_ext_sync_en,
  input  logic                    cfg_unf_stop_en,
  input  logic [NUM_CHANNELS-1:0] cfg_enable,
  input  logic                    ext_sync,
  input  logic                    link_ready,
  input  logic                    dac_dunf,
  output logic                    dac_sync,
  output logic                    link_valid_en,
  output logic [NUM_CHANNELS-1:0] enable,
  output logic [2:0]              status_state,
  output logic                    status_running,
  output logic                    status_unf_stop,
  output logic [15:0]             unf_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LINK = 3'd1,
    WAIT_TRIG = 3'd2,
    SYNC      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [10:0] STABLE_LAST = 11'(LINK_STABLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [10:0] stable_cnt_q, stable_cnt_d;
  logic [15:0] unf_count_q, unf_count_d;
  logic        unf_stop_q, unf_stop_d;
  logic        ext_sync_q;
  logic        ext_sync_rise;

  // Previous value resets high so a trigger already asserted at reset release is not an edge.
  assign ext_sync_rise = ext_sync & ~ext_sync_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      stable_cnt_q <= '0;
      unf_count_q  <= '0;
      unf_stop_q   <= 1'b0;
      ext_sync_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      unf_count_q  <= unf_count_d;
      unf_stop_q   <= unf_stop_d;
      ext_sync_q   <= ext_sync;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    unf_count_d  = unf_count_q;
    unf_stop_d   = unf_stop_q;

    // Underflow cycles in RUN are counted even on the cycle that triggers a stop.
    if (state_q == RUN && dac_dunf && unf_count_q != 16'hFFFF) begin
      unf_count_d = unf_count_q + 16'd1;
    end

    if (cfg_stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_arm) begin
            state_d      = WAIT_LINK;
            stable_cnt_d = '0;
            unf_count_d  = '0;
            unf_stop_d   = 1'b0;
          end
        end
        WAIT_LINK: begin
          if (!link_ready) begin
            stable_cnt_d = '0;
          end else if (stable_cnt_q == STABLE_LAST) begin
            stable_cnt_d = '0;
            state_d      = cfg_ext_sync_en ? WAIT_TRIG : SYNC;
          end else begin
            stable_cnt_d = stable_cnt_q + 11'd1;
          end
        end
        WAIT_TRIG: begin
          if (!link_ready) begin
            state_d      = WAIT_LINK;
            stable_cnt_d = '0;
          end else if (ext_sync_rise) begin
            state_d = SYNC;
          end
        end
        SYNC: state_d = RUN;
        RUN: begin
          if (dac_dunf && cfg_unf_stop_en) begin
            state_d    = IDLE;
            unf_stop_d = 1'b1;
          end else if (!link_ready) begin
            state_d      = WAIT_LINK;
            stable_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign status_state    = state_q;
  assign dac_sync        = (state_q == SYNC);
  assign status_running  = (state_q == RUN);
  assign link_valid_en   = status_running;
  assign enable          = status_running ? cfg_enable : '0;
  assign status_unf_stop = unf_stop_q;
  assign unf_count       = unf_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Scoreboard bench for the TPL DAC start/stop sequencer: expected outputs are queued
// with each stimulus cycle and compared after the following clock edge.
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_WLINK = 3'd1, S_WTRIG = 3'd2,
                         S_SYNC = 3'd3, S_RUN = 3'd4;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  en;
    logic        ustop;
    logic [15:0] ucnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, cfg_arm, cfg_stop, cfg_ext_sync_en, cfg_unf_stop_en;
  logic [1:0]  cfg_enable;
  logic        ext_sync, link_ready, dac_dunf;
  logic        dac_sync, link_valid_en, status_running, status_unf_stop;
  logic [1:0]  enable;
  logic [2:0]  status_state;
  logic [15:0] unf_count;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ad_ip_jesd204_tpl_dac_start_ctrl #(
    .NUM_CHANNELS(2),
    .LINK_STABLE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
    .cfg_ext_sync_en(cfg_ext_sync_en), .cfg_unf_stop_en(cfg_unf_stop_en),
    .cfg_enable(cfg_enable), .ext_sync(ext_sync), .link_ready(link_ready),
    .dac_dunf(dac_dunf), .dac_sync(dac_sync), .link_valid_en(link_valid_en),
    .enable(enable), .status_state(status_state), .status_running(status_running),
    .status_unf_stop(status_unf_stop), .unf_count(unf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the current stimulus, advance one edge, compare.
  task automatic step(input string tag, input logic [2:0] st,
                      input logic ustop, input logic [15:0] ucnt);
    exp_t e, o;
    e.st    = st;
    e.en    = (st == S_RUN) ? cfg_enable : 2'b00;
    e.ustop = ustop;
    e.ucnt  = ucnt;
    sb_q.push_back(e);
    tick();
    o = sb_q.pop_front();
    check({tag, ".state"},   32'(status_state),    32'(o.st));
    check({tag, ".sync"},    32'(dac_sync),        32'(o.st == S_SYNC));
    check({tag, ".lvalid"},  32'(link_valid_en),   32'(o.st == S_RUN));
    check({tag, ".running"}, 32'(status_running),  32'(o.st == S_RUN));
    check({tag, ".enable"},  32'(enable),          32'(o.en));
    check({tag, ".ustop"},   32'(status_unf_stop), 32'(o.ustop));
    check({tag, ".ucnt"},    32'(unf_count),       32'(o.ucnt));
  endtask

  // Arm with link_ready high and no trigger: WAIT_LINK cycles 1..16, SYNC 17, RUN 18.
  task automatic arm_to_run(input string tag);
    cfg_arm = 1'b1;
    step({tag, ".arm"}, S_WLINK, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    for (int c = 2; c <= 16; c++) step({tag, ".wlink"}, S_WLINK, 1'b0, 16'd0);
    step({tag, ".sync"}, S_SYNC, 1'b0, 16'd0);
    step({tag, ".run"}, S_RUN, 1'b0, 16'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_arm = 1'b0; cfg_stop = 1'b0; cfg_ext_sync_en = 1'b0;
    cfg_unf_stop_en = 1'b0; cfg_enable = 2'b11; ext_sync = 1'b0;
    link_ready = 1'b1; dac_dunf = 1'b0;

    step("reset", S_IDLE, 1'b0, 16'd0);
    step("reset2", S_IDLE, 1'b0, 16'd0);
    reset = 1'b0;
    step("idle", S_IDLE, 1'b0, 16'd0);

    // Basic arm latency, then RUN holds.
    arm_to_run("lat");
    step("lat.hold", S_RUN, 1'b0, 16'd0);
    cfg_stop = 1'b1;
    step("stop", S_IDLE, 1'b0, 16'd0);
    cfg_stop = 1'b0;

    // Link drop at stable count 10 restarts the count: SYNC moves to cycle 28.
    cfg_arm = 1'b1;
    step("drop.arm", S_WLINK, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    for (int c = 1; c <= 10; c++) step("drop.pre", S_WLINK, 1'b0, 16'd0);
    link_ready = 1'b0;
    step("drop.low", S_WLINK, 1'b0, 16'd0);
    link_ready = 1'b1;
    for (int c = 12; c <= 26; c++) step("drop.post", S_WLINK, 1'b0, 16'd0);
    step("drop.sync", S_SYNC, 1'b0, 16'd0);
    step("drop.run", S_RUN, 1'b0, 16'd0);

    // Link loss in RUN: back to WAIT_LINK, auto re-sync 16 cycles after link returns.
    cfg_enable = 2'b01;
    step("rl.run", S_RUN, 1'b0, 16'd0);
    link_ready = 1'b0;
    step("rl.drop", S_WLINK, 1'b0, 16'd0);
    link_ready = 1'b1;
    for (int c = 1; c <= 15; c++) step("rl.wlink", S_WLINK, 1'b0, 16'd0);
    step("rl.sync", S_SYNC, 1'b0, 16'd0);
    step("rl.run2", S_RUN, 1'b0, 16'd0);
    cfg_enable = 2'b11;

    // Underflow counting saturates without stopping, then stop-on-underflow.
    dac_dunf = 1'b1;
    step("unf.first", S_RUN, 1'b0, 16'd1);
    for (int c = 0; c < 69998; c++) tick();
    step("unf.sat", S_RUN, 1'b0, 16'hFFFF);
    cfg_unf_stop_en = 1'b1;
    step("unf.stop", S_IDLE, 1'b1, 16'hFFFF);
    dac_dunf = 1'b0;
    cfg_unf_stop_en = 1'b0;
    step("unf.idle", S_IDLE, 1'b1, 16'hFFFF);
    cfg_arm = 1'b1;
    step("unf.rearm", S_WLINK, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    cfg_stop = 1'b1;
    step("unf.abort", S_IDLE, 1'b0, 16'd0);
    cfg_stop = 1'b0;

    // External trigger held high through reset is not an edge; edge at cycle 40.
    ext_sync = 1'b1;
    reset = 1'b1;
    step("trig.reset", S_IDLE, 1'b0, 16'd0);
    reset = 1'b0;
    cfg_ext_sync_en = 1'b1;
    cfg_arm = 1'b1;
    step("trig.arm", S_WLINK, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    for (int c = 1; c <= 39; c++) begin
      ext_sync = (c < 30);
      step((c + 1 <= 16) ? "trig.wlink" : "trig.wait",
           (c + 1 <= 16) ? S_WLINK : S_WTRIG, 1'b0, 16'd0);
    end
    ext_sync = 1'b1;
    step("trig.sync", S_SYNC, 1'b0, 16'd0);
    step("trig.run", S_RUN, 1'b0, 16'd0);
    cfg_stop = 1'b1;
    step("trig.stop", S_IDLE, 1'b0, 16'd0);
    cfg_stop = 1'b0;

    // Stop while waiting for a trigger (ext_sync stays high, so no edge).
    cfg_arm = 1'b1;
    step("wt.arm", S_WLINK, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    for (int c = 2; c <= 16; c++) step("wt.wlink", S_WLINK, 1'b0, 16'd0);
    step("wt.wait", S_WTRIG, 1'b0, 16'd0);
    step("wt.hold", S_WTRIG, 1'b0, 16'd0);
    cfg_stop = 1'b1;
    step("wt.stop", S_IDLE, 1'b0, 16'd0);
    cfg_stop = 1'b0;
    cfg_ext_sync_en = 1'b0;

    // Simultaneous arm and stop in IDLE: stop wins.
    cfg_arm = 1'b1;
    cfg_stop = 1'b1;
    step("armstop", S_IDLE, 1'b0, 16'd0);
    cfg_arm = 1'b0;
    cfg_stop = 1'b0;
    step("armstop.idle", S_IDLE, 1'b0, 16'd0);

    // Reset in RUN with a nonzero underflow count returns everything to reset values.
    arm_to_run("rr");
    dac_dunf = 1'b1;
    step("rr.unf", S_RUN, 1'b0, 16'd1);
    dac_dunf = 1'b0;
    reset = 1'b1;
    step("rr.reset", S_IDLE, 1'b0, 16'd0);
    reset = 1'b0;
    step("rr.idle", S_IDLE, 1'b0, 16'd0);

    if (sb_q.size() != 0) check("sb.drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
